tlb_tag_event_sampler: RTL and testbench
========================================

TLB_TAG_EVENT_SAMPLER -- requirements
Module: tlb_tag_event_sampler

Interface
REQ-001 Parameter TLB_ENTRIES, default 16, SHALL set the number of TLB tag entries observed.
REQ-002 Parameter ASID_WIDTH, default 16, SHALL set the ASID field width per entry.
REQ-003 Parameter WINDOW_SIZE, default 5, SHALL set the event FIFO depth.
REQ-004 Port clk_i, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst_i, input, 1, SHALL be the reset: synchronous, active-high.
REQ-006 Port tlb_tags_i, input, TLB_ENTRIES*(ASID_WIDTH+30), SHALL be the live TLB tag array; per-entry layout MSB..LSB is {asid, vpn2[8:0], vpn1[8:0], vpn0[8:0], is_2M, is_1G, valid}, entry 0 in the LSBs.
REQ-007 Port sample_en_i, input, 1, SHALL gate event generation only.
REQ-008 Port evt_valid_o, input ready evt_ready_i (1 bit each), SHALL form a valid/ready output handshake.
REQ-009 Port evt_kind_o, output, 2, SHALL encode 0=FILL, 1=INVAL, 2=REPLACE, 3=FLUSH.
REQ-010 Ports evt_idx_o (4), evt_asid_o (ASID_WIDTH), evt_vpn_o (27, {vpn2,vpn1,vpn0}), evt_size_o (2: 0=4K, 1=2M, 2=1G), evt_cnt_o (5), outputs, SHALL carry the head event record.
REQ-011 Ports occ_4k_o, occ_2m_o, occ_1g_o, outputs, 5 bits each, SHALL give valid-entry counts per page size.
REQ-012 Port drop_cnt_o, output, 16, SHALL count events lost to a full FIFO or to multi-change collisions.

Function
REQ-013 Block SHALL hold a snapshot register prev_q of tlb_tags_i, updated every cycle regardless of sample_en_i.
REQ-014 Per entry, with p=prev_q, c=tlb_tags_i: FILL if p.valid=0 and c.valid=1; INVAL if p.valid=1 and c.valid=0; REPLACE if both valid and any other tag field differs; all other differences SHALL be ignored.
REQ-015 If two or more entries are INVAL in one cycle, block SHALL generate exactly one FLUSH event with evt_cnt_o = number invalidated, evt_idx_o = lowest such index, other fields from that entry's prev_q; any FILL/REPLACE in that same cycle SHALL be dropped and counted.
REQ-016 Otherwise, if multiple entries have events, the lowest index SHALL be generated and each other one SHALL increment drop_cnt_o by 1.
REQ-017 Record fields for FILL/REPLACE SHALL come from c; for INVAL from p; evt_cnt_o SHALL be 1 for non-FLUSH events.
REQ-018 evt_size_o SHALL be 2 if is_1G, else 1 if is_2M, else 0 (is_1G wins if both set).
REQ-019 Event detected in cycle N SHALL be written to the FIFO at the end of cycle N; with FIFO empty, evt_valid_o SHALL be 1 in cycle N+1 (latency 1).
REQ-020 FIFO SHALL be in-order, depth WINDOW_SIZE; head pops when evt_valid_o and evt_ready_i.
REQ-021 Simultaneous push and pop while full SHALL accept the push (no drop); push while full with no pop SHALL drop and increment drop_cnt_o.
REQ-022 Outputs evt_* SHALL be stable while evt_valid_o=1 and evt_ready_i=0.
REQ-023 drop_cnt_o SHALL saturate at 16'hFFFF; increments from one cycle SHALL be summed.
REQ-024 sample_en_i=0 SHALL suppress event generation and drop counting; FIFO draining continues.
REQ-025 occ_* SHALL be registered counts of valid entries in tlb_tags_i per REQ-018 size class, updated every cycle.

Reset
REQ-026 rst_i=1 at a rising edge SHALL clear prev_q to all zero, empty the FIFO, and zero drop_cnt_o and occ_*; evt_valid_o=0 and evt_* fields 0 the following cycle.
REQ-027 Reset mid-operation SHALL discard pending FIFO contents; the first cycle after reset SHALL compare tlb_tags_i against all-zero prev_q.

Verification
REQ-028 Entry 3 goes invalid->valid, asid=16'h0042, vpn={9'h1,9'h2,9'h3}, is_2M=1, ready=1 -> one cycle later evt_valid_o=1, kind=0, idx=3, asid=16'h0042, size=1, cnt=1.
REQ-029 Entries 0..15 valid, all invalidated in one cycle -> single FLUSH event, idx=0, cnt=16, drop_cnt_o unchanged.
REQ-030 evt_ready_i=0, six single FILLs on consecutive cycles -> FIFO holds 5, drop_cnt_o=1, events pop in order idx 0..4 once ready=1.
REQ-031 FIFO full, FILL and pop same cycle -> no drop, FIFO stays at 5 entries.
REQ-032 Entries 2 and 7 FILL same cycle -> event idx=2 only, drop_cnt_o=1; with sample_en_i=0 -> no event, drop_cnt_o unchanged.
REQ-033 Reset asserted with 3 queued events -> next cycle evt_valid_o=0, drop_cnt_o=0, occ_*=0.

Source files
------------

// File: rtl/tlb_tag_event_sampler.sv
// Watches a live TLB tag array, turns per-entry changes into FILL/INVAL/REPLACE/FLUSH
// event records, queues them in a small in-order FIFO and tracks occupancy and drops.
module tlb_tag_event_sampler #(
   parameter int unsigned TLB_ENTRIES = 16,
   parameter int unsigned ASID_WIDTH  = 16,
   parameter int unsigned WINDOW_SIZE = 5
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   input  logic [TLB_ENTRIES*(ASID_WIDTH+30)-1:0]  tlb_tags_i,
   input  logic                                    sample_en_i,
   output logic                                    evt_valid_o,
   input  logic                                    evt_ready_i,
   output logic [1:0]                              evt_kind_o,
   output logic [3:0]                              evt_idx_o,
   output logic [ASID_WIDTH-1:0]                   evt_asid_o,
   output logic [26:0]                             evt_vpn_o,
   output logic [1:0]                              evt_size_o,
   output logic [4:0]                              evt_cnt_o,
   output logic [4:0]                              occ_4k_o,
   output logic [4:0]                              occ_2m_o,
   output logic [4:0]                              occ_1g_o,
   output logic [15:0]                             drop_cnt_o
);

   localparam int unsigned EW     = ASID_WIDTH + 30;
   localparam int unsigned TW     = TLB_ENTRIES * EW;
   localparam int unsigned PTR_W  = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam int unsigned FCNT_W = $clog2(WINDOW_SIZE + 1);

   typedef enum logic [1:0] {
      KIND_FILL    = 2'd0,
      KIND_INVAL   = 2'd1,
      KIND_REPLACE = 2'd2,
      KIND_FLUSH   = 2'd3
   } kind_e;

   typedef struct packed {
      logic [1:0]            kind;
      logic [3:0]            idx;
      logic [ASID_WIDTH-1:0] asid;
      logic [26:0]           vpn;
      logic [1:0]            size;
      logic [4:0]            cnt;
   } evt_t;

   function automatic logic [1:0] size_of(input logic [EW-1:0] e);
      if (e[1]) return 2'd2;
      if (e[2]) return 2'd1;
      return 2'd0;
   endfunction

   function automatic evt_t make_rec(input kind_e k, input logic [3:0] idx,
                                     input logic [EW-1:0] e, input logic [4:0] cnt);
      evt_t r;
      r.kind = k;
      r.idx  = idx;
      r.asid = e[EW-1:30];
      r.vpn  = e[29:3];
      r.size = size_of(e);
      r.cnt  = cnt;
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(WINDOW_SIZE - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   logic [TW-1:0]     prev_q, prev_d;
   evt_t              fifo_q [WINDOW_SIZE];
   evt_t              fifo_d [WINDOW_SIZE];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic [15:0]       drop_q, drop_d;
   logic [4:0]        occ_4k_q, occ_4k_d, occ_2m_q, occ_2m_d, occ_1g_q, occ_1g_d;

   logic [EW-1:0] p_e, c_e;
   logic [4:0]    inval_n, fr_n, coll_drop;
   logic          inval_hit, any_hit, push_req, push, pop, full, full_drop;
   evt_t          inval_rec, any_rec, push_rec, head;
   logic [16:0]   drop_sum;

   assign evt_valid_o = (fcnt_q != '0);

   always_comb begin
      p_e       = '0;
      c_e       = '0;
      inval_n   = '0;
      fr_n      = '0;
      inval_hit = 1'b0;
      any_hit   = 1'b0;
      inval_rec = '0;
      any_rec   = '0;
      occ_4k_d  = '0;
      occ_2m_d  = '0;
      occ_1g_d  = '0;
      for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
         p_e = prev_q[i*EW +: EW];
         c_e = tlb_tags_i[i*EW +: EW];
         if (c_e[0]) begin
            unique case (size_of(c_e))
               2'd2:    occ_1g_d = occ_1g_d + 5'd1;
               2'd1:    occ_2m_d = occ_2m_d + 5'd1;
               default: occ_4k_d = occ_4k_d + 5'd1;
            endcase
         end
         if (p_e[0] && !c_e[0]) begin
            inval_n = inval_n + 5'd1;
            if (!inval_hit) begin
               inval_hit = 1'b1;
               inval_rec = make_rec(KIND_FLUSH, 4'(i), p_e, 5'd0);
            end
            if (!any_hit) begin
               any_hit = 1'b1;
               any_rec = make_rec(KIND_INVAL, 4'(i), p_e, 5'd1);
            end
         end else if (!p_e[0] && c_e[0]) begin
            fr_n = fr_n + 5'd1;
            if (!any_hit) begin
               any_hit = 1'b1;
               any_rec = make_rec(KIND_FILL, 4'(i), c_e, 5'd1);
            end
         end else if (p_e[0] && c_e[0] && (p_e[EW-1:1] != c_e[EW-1:1])) begin
            fr_n = fr_n + 5'd1;
            if (!any_hit) begin
               any_hit = 1'b1;
               any_rec = make_rec(KIND_REPLACE, 4'(i), c_e, 5'd1);
            end
         end
      end

      // Two or more invalidations collapse into one FLUSH; fills/replaces that cycle are lost.
      push_req  = 1'b0;
      push_rec  = any_rec;
      coll_drop = '0;
      if (sample_en_i) begin
         if (inval_n >= 5'd2) begin
            push_req     = 1'b1;
            push_rec     = inval_rec;
            push_rec.cnt = inval_n;
            coll_drop    = fr_n;
         end else if (any_hit) begin
            push_req  = 1'b1;
            coll_drop = inval_n + fr_n - 5'd1;
         end
      end

      // When full, a same-cycle pop frees the head slot, which is exactly where wr_ptr points.
      pop       = evt_valid_o && evt_ready_i;
      full      = (fcnt_q == FCNT_W'(WINDOW_SIZE));
      push      = push_req && (!full || pop);
      full_drop = push_req && full && !pop;

      fifo_d = fifo_q;
      if (push) fifo_d[wr_ptr_q] = push_rec;
      wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      fcnt_d   = fcnt_q + FCNT_W'(push) - FCNT_W'(pop);

      drop_sum = {1'b0, drop_q} + 17'(coll_drop) + 17'(full_drop);
      drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];

      prev_d = tlb_tags_i;

      head = evt_valid_o ? fifo_q[rd_ptr_q] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q   <= '0;
         for (int unsigned k = 0; k < WINDOW_SIZE; k++) fifo_q[k] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         fcnt_q   <= '0;
         drop_q   <= '0;
         occ_4k_q <= '0;
         occ_2m_q <= '0;
         occ_1g_q <= '0;
      end else begin
         prev_q   <= prev_d;
         fifo_q   <= fifo_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         fcnt_q   <= fcnt_d;
         drop_q   <= drop_d;
         occ_4k_q <= occ_4k_d;
         occ_2m_q <= occ_2m_d;
         occ_1g_q <= occ_1g_d;
      end
   end

   assign evt_kind_o = head.kind;
   assign evt_idx_o  = head.idx;
   assign evt_asid_o = head.asid;
   assign evt_vpn_o  = head.vpn;
   assign evt_size_o = head.size;
   assign evt_cnt_o  = head.cnt;
   assign occ_4k_o   = occ_4k_q;
   assign occ_2m_o   = occ_2m_q;
   assign occ_1g_o   = occ_1g_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_tlb_tag_event_sampler.sv
// Scoreboard bench: a field-level model predicts events/drops/occupancy; a negedge monitor compares.
module tb_tlb_tag_event_sampler;

   localparam int N     = 16;
   localparam int AW    = 16;
   localparam int EW    = AW + 30;
   localparam int DEPTH = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N*EW-1:0] tags;
   logic            sample_en, ready;
   logic            evt_valid;
   logic [1:0]      evt_kind, evt_size;
   logic [3:0]      evt_idx;
   logic [AW-1:0]   evt_asid;
   logic [26:0]     evt_vpn;
   logic [4:0]      evt_cnt, occ_4k, occ_2m, occ_1g;
   logic [15:0]     drop_cnt;

   always #5 clk = ~clk;

   tlb_tag_event_sampler #(.TLB_ENTRIES(N), .ASID_WIDTH(AW), .WINDOW_SIZE(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .tlb_tags_i(tags), .sample_en_i(sample_en),
      .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_kind_o(evt_kind),
      .evt_idx_o(evt_idx), .evt_asid_o(evt_asid), .evt_vpn_o(evt_vpn),
      .evt_size_o(evt_size), .evt_cnt_o(evt_cnt), .occ_4k_o(occ_4k),
      .occ_2m_o(occ_2m), .occ_1g_o(occ_1g), .drop_cnt_o(drop_cnt));

   typedef struct packed {
      logic          valid, is1g, is2m;
      logic [8:0]    v2, v1, v0;
      logic [AW-1:0] asid;
   } ent_t;

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic ent_t dec(input logic [EW-1:0] e);
      ent_t r;
      r.valid = e[0]; r.is1g = e[1]; r.is2m = e[2];
      r.v0 = e[11:3]; r.v1 = e[20:12]; r.v2 = e[29:21]; r.asid = e[EW-1:30];
      return r;
   endfunction

   function automatic int size_cls(input ent_t e);
      return e.is1g ? 2 : (e.is2m ? 1 : 0);
   endfunction

   function automatic logic [63:0] pack(input int k, input int idx, input ent_t e, input int cnt);
      return {8'd0, 2'(k), 4'(idx), e.asid, e.v2, e.v1, e.v0, 2'(size_cls(e)), 5'(cnt)};
   endfunction

   function automatic logic [EW-1:0] rnd_ent(input logic valid);
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return {r[EW-1:1], valid};
   endfunction

   // ---------------- reference model ----------------
   ent_t        prev_m [N];
   ent_t        cur    [N];
   logic [63:0] exp_q  [$];
   int          inv    [$];
   int          chg    [$];
   int          mcount = 0, exp_drop = 0, o4 = 0, o2 = 0, o1 = 0;
   int          drops, lo;
   bit          have, mpop;
   logic [63:0] rec;
   bit          mon_en = 0;

   always @(posedge clk) begin
      if (rst) begin
         foreach (prev_m[i]) prev_m[i] = '0;
         exp_q.delete();
         mcount = 0; exp_drop = 0; o4 = 0; o2 = 0; o1 = 0;
      end else begin
         for (int i = 0; i < N; i++) cur[i] = dec(tags[i*EW +: EW]);
         o4 = 0; o2 = 0; o1 = 0;
         for (int i = 0; i < N; i++)
            if (cur[i].valid) begin
               if (size_cls(cur[i]) == 2) o1++;
               else if (size_cls(cur[i]) == 1) o2++;
               else o4++;
            end
         mpop  = ready && (mcount > 0);
         have  = 0;
         drops = 0;
         if (sample_en) begin
            inv.delete();
            chg.delete();
            for (int i = 0; i < N; i++) begin
               if (prev_m[i].valid && !cur[i].valid) inv.push_back(i);
               else if (!prev_m[i].valid && cur[i].valid) chg.push_back(i);
               else if (prev_m[i].valid && cur[i].valid &&
                        ({prev_m[i].asid, prev_m[i].v2, prev_m[i].v1, prev_m[i].v0, prev_m[i].is2m, prev_m[i].is1g} !=
                         {cur[i].asid, cur[i].v2, cur[i].v1, cur[i].v0, cur[i].is2m, cur[i].is1g}))
                  chg.push_back(i);
            end
            if (inv.size() >= 2) begin
               rec   = pack(3, inv[0], prev_m[inv[0]], inv.size());
               drops = chg.size();
               have  = 1;
            end else if (inv.size() + chg.size() > 0) begin
               lo = N;
               if (inv.size() > 0) lo = inv[0];
               if (chg.size() > 0 && chg[0] < lo) lo = chg[0];
               if (inv.size() == 1 && inv[0] == lo) rec = pack(1, lo, prev_m[lo], 1);
               else rec = pack(prev_m[lo].valid ? 2 : 0, lo, cur[lo], 1);
               drops = inv.size() + chg.size() - 1;
               have  = 1;
            end
            if (have) begin
               if (mcount < DEPTH || mpop) begin
                  exp_q.push_back(rec);
                  mcount++;
               end else drops++;
            end
         end
         if (mpop) mcount--;
         exp_drop = (exp_drop + drops > 65535) ? 65535 : exp_drop + drops;
         prev_m = cur;
      end
   end

   // ---------------- monitor ----------------
   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         chk("valid", 64'(evt_valid), 64'(exp_q.size() != 0));
         if (evt_valid && exp_q.size() != 0) begin
            chk("event", {8'd0, evt_kind, evt_idx, evt_asid, evt_vpn, evt_size, evt_cnt}, exp_q[0]);
            if (ready) void'(exp_q.pop_front());
         end else if (!evt_valid) begin
            chk("idle_fields", {8'd0, evt_kind, evt_idx, evt_asid, evt_vpn, evt_size, evt_cnt}, 64'd0);
         end
         chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
         chk("occ", {49'd0, occ_4k, occ_2m, occ_1g}, {49'd0, 5'(o4), 5'(o2), 5'(o1)});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ent(input int i, input logic [EW-1:0] e);
      tags[i*EW +: EW] = e;
   endtask

   task automatic do_reset();
      tags = '0;
      rst  = 1'b1;
      step();
      rst  = 1'b0;
   endtask

   logic [EW-1:0] e0, e;
   int            r, idx;

   initial begin
      rst = 1'b1; tags = '0; sample_en = 1'b1; ready = 1'b1;
      step();
      step();
      mon_en = 1;
      rst = 1'b0;
      chk("reset_valid", 64'(evt_valid), 64'd0);
      chk("reset_drop", 64'(drop_cnt), 64'd0);

      // single 2M fill on entry 3
      set_ent(3, {16'h0042, 9'h1, 9'h2, 9'h3, 1'b1, 1'b0, 1'b1});
      step();
      chk("fill_valid", 64'(evt_valid), 64'd1);
      chk("fill_rec", {8'd0, evt_kind, evt_idx, evt_asid, evt_vpn, evt_size, evt_cnt},
          {8'd0, 2'd0, 4'd3, 16'h0042, 9'h1, 9'h2, 9'h3, 2'd1, 5'd1});
      step();

      // fill all 16 one per cycle, then invalidate all at once
      do_reset();
      ready = 1'b1;
      e0 = rnd_ent(1'b1);
      for (int i = 0; i < N; i++) begin
         set_ent(i, (i == 0) ? e0 : rnd_ent(1'b1));
         step();
      end
      step();
      tags = '0;
      step();
      chk("flush_rec", {8'd0, evt_kind, evt_idx, evt_asid, evt_vpn, evt_size, evt_cnt},
          pack(3, 0, dec(e0), 16));
      chk("flush_drop", 64'(drop_cnt), 64'd0);
      step();

      // overflow: six fills with ready low
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_ent(i, rnd_ent(1'b1));
         step();
      end
      chk("ovf_drop", 64'(drop_cnt), 64'd1);
      ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("ovf_order", 64'(evt_idx), 64'(k));
         step();
      end
      chk("ovf_empty", 64'(evt_valid), 64'd0);

      // full FIFO with simultaneous push and pop
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_ent(i, rnd_ent(1'b1));
         step();
      end
      set_ent(5, rnd_ent(1'b1));
      ready = 1'b1;
      step();
      chk("fullpp_drop", 64'(drop_cnt), 64'd0);
      for (int k = 1; k < 6; k++) begin
         chk("fullpp_order", 64'(evt_idx), 64'(k));
         step();
      end
      chk("fullpp_empty", 64'(evt_valid), 64'd0);

      // collision on entries 2 and 7, then the same with sampling disabled
      do_reset();
      ready = 1'b0;
      set_ent(2, rnd_ent(1'b1));
      set_ent(7, rnd_ent(1'b1));
      step();
      chk("coll_idx", 64'(evt_idx), 64'd2);
      chk("coll_drop", 64'(drop_cnt), 64'd1);
      sample_en = 1'b0;
      set_ent(2, '0);
      set_ent(7, '0);
      step();
      set_ent(9, rnd_ent(1'b1));
      set_ent(11, rnd_ent(1'b1));
      step();
      chk("dis_drop", 64'(drop_cnt), 64'd1);
      sample_en = 1'b1;
      ready = 1'b1;
      step();
      step();
      chk("dis_noevt", 64'(evt_valid), 64'd0);

      // reset with queued events
      do_reset();
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_ent(i, rnd_ent(1'b1));
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_q_valid", 64'(evt_valid), 64'd0);
      chk("rst_q_drop", 64'(drop_cnt), 64'd0);
      chk("rst_q_occ", {49'd0, occ_4k, occ_2m, occ_1g}, 64'd0);

      // randomized traffic
      for (int cyc = 0; cyc < 4000; cyc++) begin
         ready     = ($urandom_range(0, 99) < 60);
         sample_en = ($urandom_range(0, 99) < 90);
         rst       = ($urandom_range(0, 999) < 3);
         r = $urandom_range(0, 99);
         if (r < 5) begin
            for (int i = 0; i < N; i++)
               if ($urandom_range(0, 9) < 7) tags[i*EW] = 1'b0;
         end else if (r < 60) begin
            repeat ($urandom_range(1, 3)) begin
               idx = $urandom_range(0, N - 1);
               e   = tags[idx*EW +: EW];
               case ($urandom_range(0, 3))
                  0:       e[0] = ~e[0];
                  1:       e = rnd_ent(e[0]);
                  2:       e[2:1] = 2'($urandom_range(0, 3));
                  default: e = rnd_ent(1'($urandom_range(0, 1)));
               endcase
               set_ent(idx, e);
            end
         end
         step();
      end

      rst = 1'b0;
      sample_en = 1'b0;
      ready = 1'b1;
      repeat (10) step();
      chk("final_drain", 64'(evt_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
